// File: rtl/prbs_checker.sv
// prbs_checker
// Receive-side PRBS checker. A local copy of the generator LFSR is loaded
// directly from the incoming bit stream while hunting. Once enough consecutive
// bits match its prediction, the checker declares lock and lets the LFSR
// free-run. In lock it counts checked bits and errored bits for BER readout.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   enable     0 freezes all state (din_valid ignored)
//   clear      synchronous zero of bit_count / err_count / loss_count
//   din        received PRBS bit
//   din_valid  din is sampled on this edge when enable=1
//   locked     1 while in LOCKED
//   err_o      one-cycle pulse per errored bit checked in LOCKED
//   bit_count  bits checked while LOCKED (saturating)
//   err_count  errored bits while LOCKED (saturating)
//   loss_count LOCKED->HUNT transitions (saturating at 255)
module prbs_checker #(
   parameter int                    LFSR_WIDTH = 8,
   parameter logic [LFSR_WIDTH-1:0] LFSR_POLY  = 8'hBE,
   parameter int                    LOCK_COUNT = 16,
   parameter int                    LOSS_COUNT = 4,
   parameter int                    CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             clear,
   input  logic             din,
   input  logic             din_valid,
   output logic             locked,
   output logic             err_o,
   output logic [CNT_W-1:0] bit_count,
   output logic [CNT_W-1:0] err_count,
   output logic [7:0]       loss_count
);

   localparam int FILL_W = $clog2(LFSR_WIDTH + 1);

   typedef enum logic {HUNT, LOCKED} state_t;

   state_t                state;
   logic [LFSR_WIDTH-1:0] s;
   logic [FILL_W-1:0]     fill_cnt;
   logic [7:0]            match_cnt;
   logic [3:0]            bad_cnt;

   logic accepted;
   logic exp_bit;
   logic err_bit;
   logic fill_done;

   always_comb begin
      accepted  = enable & din_valid;
      exp_bit   = ^(s & LFSR_POLY);
      err_bit   = din ^ exp_bit;
      fill_done = (fill_cnt == FILL_W'(LFSR_WIDTH));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= HUNT;
         s          <= '0;
         fill_cnt   <= '0;
         match_cnt  <= '0;
         bad_cnt    <= '0;
         locked     <= 1'b0;
         err_o      <= 1'b0;
         bit_count  <= '0;
         err_count  <= '0;
         loss_count <= '0;
      end else begin
         // err_o is a pulse: low unless this edge checks an errored bit
         err_o <= 1'b0;
         if (accepted) begin
            case (state)
               HUNT: begin
                  // self-synchronising load: the received bit becomes LFSR state
                  s <= {s[LFSR_WIDTH-2:0], din};
                  if (!fill_done) begin
                     fill_cnt <= fill_cnt + 1'b1;
                  end else if (!err_bit && (s != '0)) begin
                     if (match_cnt == 8'(LOCK_COUNT - 1)) begin
                        state     <= LOCKED;
                        locked    <= 1'b1;
                        match_cnt <= '0;
                     end else begin
                        match_cnt <= match_cnt + 1'b1;
                     end
                  end else begin
                     // a mismatch, or a match from all-zero state, restarts
                     // the run so an all-zero line can never lock
                     match_cnt <= '0;
                  end
               end
               LOCKED: begin
                  // free-run so a line error never enters the LFSR
                  s <= {s[LFSR_WIDTH-2:0], exp_bit};
                  if (bit_count != '1) bit_count <= bit_count + 1'b1;
                  if (err_bit) begin
                     err_o <= 1'b1;
                     if (err_count != '1) err_count <= err_count + 1'b1;
                     if (bad_cnt == 4'(LOSS_COUNT - 1)) begin
                        state     <= HUNT;
                        locked    <= 1'b0;
                        fill_cnt  <= '0;
                        match_cnt <= '0;
                        bad_cnt   <= '0;
                        if (loss_count != 8'hFF) loss_count <= loss_count + 1'b1;
                     end else begin
                        bad_cnt <= bad_cnt + 1'b1;
                     end
                  end else begin
                     bad_cnt <= '0;
                  end
               end
               default: state <= HUNT;
            endcase
         end
         // clear overrides any same-edge counter increment
         if (clear) begin
            bit_count  <= '0;
            err_count  <= '0;
            loss_count <= '0;
         end
      end
   end

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: a window/queue-based model of the checker's rules
// checked against the DUT every cycle, plus literal expectations per scenario.
module tb_prbs_checker;

   localparam int         W     = 8;
   localparam logic [7:0] POLY  = 8'hBE;
   localparam int         LOCKN = 16;
   localparam int         LOSSN = 4;
   localparam longint     MAXC  = 64'h0000_0000_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst_n, enable, clear, din, din_valid;
   logic        locked, err_o;
   logic [31:0] bit_count, err_count;
   logic [7:0]  loss_count;

   prbs_checker dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
      .din(din), .din_valid(din_valid), .locked(locked), .err_o(err_o),
      .bit_count(bit_count), .err_count(err_count), .loss_count(loss_count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // win holds the last W bits that entered the LFSR, oldest first.
   bit     win[$];
   bit     m_locked, m_err;
   int     m_fill, m_match, m_bad, m_acc;
   longint m_bits, m_errs, m_loss;

   function automatic bit predict();
      bit p = 0;
      for (int i = 0; i < W; i++)
         if (POLY[i]) p ^= win[W-1-i];
      return p;
   endfunction

   function automatic bit win_zero();
      foreach (win[i]) if (win[i]) return 0;
      return 1;
   endfunction

   task automatic model_reset();
      win.delete();
      for (int i = 0; i < W; i++) win.push_back(1'b0);
      m_locked = 0; m_err = 0; m_fill = 0; m_match = 0; m_bad = 0; m_acc = 0;
      m_bits = 0; m_errs = 0; m_loss = 0;
   endtask

   task automatic model_step();
      bit p;
      m_err = 0;
      if (enable && din_valid) begin
         m_acc++;
         p = predict();
         if (!m_locked) begin
            if (m_fill < W) m_fill++;
            else if (din == p && !win_zero()) begin
               m_match++;
               if (m_match == LOCKN) begin m_locked = 1; m_match = 0; end
            end else m_match = 0;
            win.push_back(din);
         end else begin
            if (m_bits < MAXC) m_bits++;
            if (din != p) begin
               m_err = 1;
               if (m_errs < MAXC) m_errs++;
               m_bad++;
               if (m_bad == LOSSN) begin
                  m_locked = 0; m_fill = 0; m_match = 0; m_bad = 0;
                  if (m_loss < 255) m_loss++;
               end
            end else m_bad = 0;
            win.push_back(p);
         end
         void'(win.pop_front());
      end
      if (clear) begin m_bits = 0; m_errs = 0; m_loss = 0; end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else model_step();
      end
   end

   // ---------------- per-cycle compare + monitors ----------------
   bit chk_en = 0;
   bit prev_locked = 0;
   int lock_at = 0;
   int err_pulses = 0;
   int lock_cycles = 0;

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("cyc_locked", locked, m_locked);
         chk("cyc_err_o", err_o, m_err);
         chk("cyc_bit_count", bit_count, m_bits);
         chk("cyc_err_count", err_count, m_errs);
         chk("cyc_loss_count", loss_count, m_loss);
      end
      if (locked && !prev_locked) lock_at = m_acc;
      if (err_o) err_pulses++;
      if (locked) lock_cycles++;
      prev_locked = locked;
   end

   // ---------------- stimulus ----------------
   logic [7:0] g;

   task automatic gen_bit(output logic b);
      b = ^(g & POLY);
      g = {g[6:0], b};
   endtask

   task automatic drive(input logic b, input logic v, input logic e, input logic c);
      @(negedge clk);
      din = b; din_valid = v; enable = e; clear = c;
   endtask

   task automatic settle();
      drive(1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic send_clean(input int n);
      logic b;
      for (int i = 0; i < n; i++) begin gen_bit(b); drive(b, 1'b1, 1'b1, 1'b0); end
   endtask

   task automatic send_bad(input int n);
      logic b;
      for (int i = 0; i < n; i++) begin gen_bit(b); drive(~b, 1'b1, 1'b1, 1'b0); end
   endtask

   initial begin
      logic b;
      int   base, n_acc;
      rst_n = 0; enable = 0; clear = 0; din = 0; din_valid = 0;
      #3;
      chk("rst_locked", locked, 0);
      chk("rst_err_o", err_o, 0);
      chk("rst_bit_count", bit_count, 0);
      chk("rst_loss_count", loss_count, 0);
      @(negedge clk); rst_n = 1; enable = 1;
      chk_en = 1;

      // clean lock: bit 24 locks, not bit 23
      g = 8'hEF;
      send_clean(23); settle();
      chk("lock_not_at_23", locked, 0);
      send_clean(1); settle();
      chk("lock_at_24", lock_at, 24);
      chk("locked_after_24", locked, 1);
      err_pulses = 0;
      send_clean(100); settle();
      chk("clean_bit_count", bit_count, 100);
      chk("clean_err_count", err_count, 0);
      chk("clean_err_pulses", err_pulses, 0);

      // single error at bit 50, no propagation
      send_clean(49); send_bad(1); settle();
      chk("single_err_o", err_o, 1);
      send_clean(30); settle();
      chk("single_err_pulses", err_pulses, 1);
      chk("single_err_count", err_count, 1);
      chk("single_locked", locked, 1);
      chk("single_bit_count", bit_count, 180);

      // loss of lock after 4 consecutive errors, then relock in 24
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      send_bad(3); settle();
      chk("loss_still_locked_3", locked, 1);
      send_bad(1); settle();
      chk("loss_locked", locked, 0);
      chk("loss_err_count", err_count, 4);
      chk("loss_loss_count", loss_count, 1);
      base = m_acc;
      send_clean(23); settle();
      chk("relock_not_yet", locked, 0);
      send_clean(1); settle();
      chk("relock_locked", locked, 1);
      chk("relock_at", lock_at - base, 24);

      // clear together with an errored bit
      send_clean(5);
      gen_bit(b); drive(~b, 1'b1, 1'b1, 1'b1); settle();
      chk("clr_bit_count", bit_count, 0);
      chk("clr_err_count", err_count, 0);
      chk("clr_err_o", err_o, 1);
      chk("clr_locked", locked, 1);

      // asynchronous reset mid-stream
      send_clean(3);
      @(negedge clk); #2; rst_n = 0; #1;
      chk("async_locked", locked, 0);
      chk("async_bit_count", bit_count, 0);
      chk("async_loss_count", loss_count, 0);
      @(negedge clk); rst_n = 1;

      // zero stream never locks
      lock_cycles = 0;
      for (int i = 0; i < 1000; i++) drive(1'b0, 1'b1, 1'b1, 1'b0);
      settle();
      chk("zero_lock_cycles", lock_cycles, 0);
      chk("zero_bit_count", bit_count, 0);
      chk("zero_err_count", err_count, 0);
      chk("zero_loss_count", loss_count, 0);

      // gaps on din_valid and an enable drop while locked
      rst_n = 0; #1; rst_n = 1;
      g = 8'hEF; lock_at = 0; n_acc = 0;
      while (n_acc < 24) begin
         if ($urandom_range(0, 1) == 1) begin
            gen_bit(b); drive(b, 1'b1, 1'b1, 1'b0); n_acc++;
         end else drive(1'b1, 1'b0, 1'b1, 1'b0);
      end
      settle();
      chk("gap_lock_at", lock_at, 24);
      chk("gap_locked", locked, 1);
      n_acc = 0;
      while (n_acc < 20) begin
         if ($urandom_range(0, 1) == 1) begin
            gen_bit(b); drive(b, 1'b1, 1'b1, 1'b0); n_acc++;
         end else drive(1'b0, 1'b0, 1'b1, 1'b0);
      end
      settle();
      chk("gap_bit_count", bit_count, 20);
      for (int i = 0; i < 10; i++) drive(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
      settle();
      chk("en_frozen_bits", bit_count, 20);
      chk("en_frozen_locked", locked, 1);
      send_clean(10); settle();
      chk("en_resume_bits", bit_count, 30);
      chk("en_resume_errs", err_count, 0);

      settle();
      chk_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // global watchdog
   initial begin
      #500000;
      bad++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
